// File: rtl/gate_pkg.sv
// rtl/gate_pkg.sv - shared gate state encoding and default timing constants
package gate_pkg;

  localparam logic [2:0] ST_DEAD_CLOSE = 3'd0;
  localparam logic [2:0] ST_CLOSING    = 3'd1;
  localparam logic [2:0] ST_CLOSED     = 3'd2;
  localparam logic [2:0] ST_DEAD_OPEN  = 3'd3;
  localparam logic [2:0] ST_OPENING    = 3'd4;
  localparam logic [2:0] ST_OPENED     = 3'd5;
  localparam logic [2:0] ST_FAULT      = 3'd6;

  localparam int DEF_TIMEOUT_CYCLES  = 1000;
  localparam int DEF_DEADTIME_CYCLES = 4;

  function automatic logic state_busy(input logic [2:0] s);
    return (s == ST_DEAD_CLOSE) || (s == ST_CLOSING) ||
           (s == ST_DEAD_OPEN)  || (s == ST_OPENING);
  endfunction

endpackage

// File: rtl/gate_travel_timer.sv
// rtl/gate_travel_timer.sv - saturating in-state cycle counter with dead-time and timeout flags
module gate_travel_timer
  import gate_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int DEADTIME_CYCLES = DEF_DEADTIME_CYCLES,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic en_i,
  output logic dead_done_o,
  output logic travel_timeout_o
);

  localparam logic [CNT_W:0] DEAD_LIM    = (CNT_W+1)'(DEADTIME_CYCLES);
  localparam logic [CNT_W:0] TIMEOUT_LIM = (CNT_W+1)'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   elapsed;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flags fire on the edge that completes the Nth cycle in the state, so dead-time lasts exactly N cycles.
  assign elapsed          = {1'b0, cnt_q} + (CNT_W+1)'(1);
  assign dead_done_o      = en_i && (elapsed == DEAD_LIM);
  assign travel_timeout_o = en_i && (elapsed == TIMEOUT_LIM);

endmodule

// File: rtl/gate_motor_driver.sv
// rtl/gate_motor_driver.sv - reversible gate motor FSM with dead-time, limits, obstruction and fault
module gate_motor_driver
  import gate_pkg::*;
#(
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int DEADTIME_CYCLES = DEF_DEADTIME_CYCLES,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic gate_open,
  input  logic gate_close,
  input  logic limit_open,
  input  logic limit_closed,
  input  logic obstruction,
  output logic motor_fwd,
  output logic motor_rev,
  output logic gate_is_open,
  output logic gate_is_closed,
  output logic busy,
  output logic fault
);

  logic [2:0] state_q, state_d;
  logic       dead_done, travel_timeout;
  logic       open_only;

  // Close wins whenever both commands arrive together.
  assign open_only = gate_open && !gate_close;

  always_comb begin
    state_d = state_q;
    if (limit_open && limit_closed && (state_q != ST_FAULT)) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_DEAD_CLOSE: begin
          if (open_only)      state_d = ST_DEAD_OPEN;
          else if (dead_done) state_d = ST_CLOSING;
        end
        ST_DEAD_OPEN: begin
          if (gate_close)     state_d = ST_DEAD_CLOSE;
          else if (dead_done) state_d = ST_OPENING;
        end
        ST_OPENING: begin
          if (limit_open)          state_d = ST_OPENED;
          else if (gate_close)     state_d = ST_DEAD_CLOSE;
          else if (travel_timeout) state_d = ST_FAULT;
        end
        ST_CLOSING: begin
          if (limit_closed)                  state_d = ST_CLOSED;
          else if (obstruction || open_only) state_d = ST_DEAD_OPEN;
          else if (travel_timeout)           state_d = ST_FAULT;
        end
        ST_OPENED: if (gate_close) state_d = ST_DEAD_CLOSE;
        ST_CLOSED: if (open_only)  state_d = ST_DEAD_OPEN;
        ST_FAULT:  state_d = ST_FAULT;
        default:   state_d = ST_FAULT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_DEAD_CLOSE;
    end else begin
      state_q <= state_d;
    end
  end

  gate_travel_timer #(
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES),
    .DEADTIME_CYCLES (DEADTIME_CYCLES),
    .CNT_W           (CNT_W)
  ) u_timer (
    .clk              (clk),
    .reset            (reset),
    .clear_i          (state_d != state_q),
    .en_i             (state_busy(state_q)),
    .dead_done_o      (dead_done),
    .travel_timeout_o (travel_timeout)
  );

  assign motor_fwd      = (state_q == ST_OPENING);
  assign motor_rev      = (state_q == ST_CLOSING);
  assign gate_is_open   = (state_q == ST_OPENED);
  assign gate_is_closed = (state_q == ST_CLOSED);
  assign busy           = state_busy(state_q);
  assign fault          = (state_q == ST_FAULT);

endmodule

// File: tb/tb_gate_motor_driver.sv
// tb/tb_gate_motor_driver.sv - directed scoreboard bench for gate_motor_driver
module tb_gate_motor_driver;

  // Output vector order: {motor_fwd, motor_rev, gate_is_open, gate_is_closed, busy, fault}
  localparam logic [5:0] E_DEAD    = 6'b000010;
  localparam logic [5:0] E_CLOSING = 6'b010010;
  localparam logic [5:0] E_OPENING = 6'b100010;
  localparam logic [5:0] E_OPENED  = 6'b001000;
  localparam logic [5:0] E_CLOSED  = 6'b000100;
  localparam logic [5:0] E_FAULT   = 6'b000001;

  typedef struct {
    string      tag;
    logic [5:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic gate_open = 1'b0, gate_close = 1'b0;
  logic limit_open = 1'b0, limit_closed = 1'b0, obstruction = 1'b0;
  logic motor_fwd, motor_rev, gate_is_open, gate_is_closed, busy, fault;

  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  gate_motor_driver #(
    .TIMEOUT_CYCLES  (20),
    .DEADTIME_CYCLES (4),
    .CNT_W           (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .gate_open      (gate_open),
    .gate_close     (gate_close),
    .limit_open     (limit_open),
    .limit_closed   (limit_closed),
    .obstruction    (obstruction),
    .motor_fwd      (motor_fwd),
    .motor_rev      (motor_rev),
    .gate_is_open   (gate_is_open),
    .gate_is_closed (gate_is_closed),
    .busy           (busy),
    .fault          (fault)
  );

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare just after the edge.
  task automatic cyc(input logic go, input logic gc, input logic lo, input logic lc,
                     input logic ob, input logic [5:0] exp, input string tag);
    exp_t e;
    logic [5:0] obs;
    gate_open    = go;
    gate_close   = gc;
    limit_open   = lo;
    limit_closed = lc;
    obstruction  = ob;
    e.tag = tag;
    e.v   = exp;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e   = sb_q.pop_front();
    obs = {motor_fwd, motor_rev, gate_is_open, gate_is_closed, busy, fault};
    checks++;
    assert (obs === e.v) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.v);
    end
  endtask

  initial begin
    // Reset and homing
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0, E_DEAD, "reset_state");
    cyc(0, 0, 0, 0, 0, E_DEAD, "reset_hold");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, E_DEAD, "home_deadtime");
    cyc(0, 0, 0, 0, 0, E_CLOSING, "home_motor_rev");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, E_CLOSING, "home_closing");
    cyc(0, 0, 0, 1, 0, E_CLOSED, "home_limit_closed");
    cyc(1, 1, 0, 1, 0, E_CLOSED, "closed_both_cmds");
    cyc(0, 1, 0, 1, 0, E_CLOSED, "closed_close_ignored");

    // Open cycle
    cyc(1, 0, 0, 1, 0, E_DEAD, "open_cmd_dead");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0, E_DEAD, "open_deadtime");
    cyc(0, 0, 0, 0, 0, E_OPENING, "open_motor_fwd");
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, (i == 2), E_OPENING, "opening_obstr_ignored");
    cyc(0, 0, 1, 0, 0, E_OPENED, "open_limit_open");
    cyc(1, 0, 1, 0, 0, E_OPENED, "opened_open_ignored");

    // Both commands in OPENED, then obstruction reversal while closing
    cyc(1, 1, 1, 0, 0, E_DEAD, "opened_both_cmds");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, E_DEAD, "close_deadtime");
    cyc(0, 0, 0, 0, 0, E_CLOSING, "close_motor_rev");
    cyc(1, 1, 0, 0, 0, E_CLOSING, "closing_both_keep");
    cyc(1, 1, 0, 0, 1, E_DEAD, "obstr_both_reverse");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, E_DEAD, "obstr_deadtime");
    cyc(0, 0, 0, 0, 0, E_OPENING, "obstr_motor_fwd");

    // Dead-time restart on opposite commands
    cyc(0, 1, 0, 0, 0, E_DEAD, "opening_close_cmd");
    cyc(0, 0, 0, 0, 0, E_DEAD, "dead_close_wait");
    cyc(1, 0, 0, 0, 0, E_DEAD, "dead_restart_open");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, E_DEAD, "restart_deadtime");
    cyc(0, 0, 0, 0, 0, E_OPENING, "restart_motor_fwd");

    // Travel timeout in OPENING
    for (int i = 0; i < 19; i++) cyc(0, 0, 0, 0, 0, E_OPENING, "timeout_pre");
    cyc(0, 0, 0, 0, 0, E_FAULT, "timeout_fault");
    cyc(1, 0, 0, 0, 0, E_FAULT, "fault_ignore_open");
    cyc(0, 1, 0, 0, 0, E_FAULT, "fault_ignore_close");
    cyc(0, 0, 1, 1, 1, E_FAULT, "fault_ignore_limits");

    // Reset clears fault and re-homes; limit on the timeout edge wins
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0, E_DEAD, "rehome_reset");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, E_DEAD, "rehome_deadtime");
    cyc(0, 0, 0, 0, 0, E_CLOSING, "rehome_closing");
    for (int i = 0; i < 19; i++) cyc(0, 0, 0, 0, 0, E_CLOSING, "rehome_travel");
    cyc(0, 0, 0, 1, 0, E_CLOSED, "limit_beats_timeout");

    // Inconsistent limits in OPENED
    cyc(1, 0, 0, 1, 0, E_DEAD, "reopen_cmd");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, E_DEAD, "reopen_deadtime");
    cyc(0, 0, 0, 0, 0, E_OPENING, "reopen_motor_fwd");
    cyc(0, 0, 1, 0, 0, E_OPENED, "reopen_opened");
    cyc(0, 0, 1, 1, 0, E_FAULT, "opened_both_limits");
    cyc(0, 0, 0, 0, 0, E_FAULT, "sensor_fault_sticky");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
